psum_out_collector: RTL and testbench

Sequencing and packing stage directly downstream of the per-PE `psum_out_router` instances. It walks the router IDs in order, driving the shared `source_id` and a one-cycle `psum_out_start`. It collects the psum beats each selected PE places on the shared psum bus, packs `PACK` psums per output word, and buffers the words in a FIFO toward the global buffer using a valid/ready handshake.

---
 rtl/psum_out_collector_if.sv | 32 +++
 rtl/psum_out_collector.sv | 200 ++++++++++++++++++++
 tb/tb_psum_out_collector.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/psum_out_collector_if.sv
// Bundle of the control, router-facing and output-stream signals of psum_out_collector.
// The collector takes the slave view; a controller/testbench drives through master.
interface psum_out_collector_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned PACK       = 4
);
  logic                       start;
  logic [ID_WIDTH-1:0]        id_first;
  logic [ID_WIDTH-1:0]        id_last;
  logic [15:0]                psum_per_id;
  logic [ID_WIDTH-1:0]        source_id;
  logic                       psum_out_start;
  logic [DATA_WIDTH-1:0]      bus_data;
  logic                       bus_en;
  logic [PACK*DATA_WIDTH-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;
  logic                       done;
  logic                       err;

  modport master (
    output start, id_first, id_last, psum_per_id, bus_data, bus_en, out_ready,
    input  source_id, psum_out_start, out_data, out_valid, busy, done, err
  );

  modport slave (
    input  start, id_first, id_last, psum_per_id, bus_data, bus_en, out_ready,
    output source_id, psum_out_start, out_data, out_valid, busy, done, err
  );
endinterface

// File: rtl/psum_out_collector.sv
// Walks router IDs, collects each PE's psum beats from the shared bus, packs PACK psums
// per word and buffers the words in a first-word-fall-through FIFO toward the global buffer.
module psum_out_collector #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input logic                clk,
  input logic                rst,
  psum_out_collector_if.slave bus
);

  localparam int unsigned WordW = PACK * DATA_WIDTH;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StCollect, StFlush, StDone} state_e;

  state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]  source_id_q, source_id_d;
  logic [ID_WIDTH-1:0]  id_last_q, id_last_d;
  logic [15:0]          ppi_q, ppi_d;
  logic [15:0]          beat_cnt_q, beat_cnt_d;
  logic [LaneW-1:0]     lane_cnt_q, lane_cnt_d;
  logic [WordW-1:0]     pack_q, pack_d;
  logic                 psum_out_start_q, psum_out_start_d;
  logic                 err_q, err_d;

  logic [WordW-1:0]     mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AddrW:0]       count_q, count_d;

  logic                 push, pop, fifo_full, fifo_empty;
  logic                 beat_ok, stray;
  logic [WordW-1:0]     push_word, beat_word;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AddrW+1)'(FIFO_DEPTH));
  assign pop        = !fifo_empty && bus.out_ready;

  // A beat counts only in COLLECT while the per-ID quota is still open.
  assign beat_ok = bus.bus_en && (state_q == StCollect) && (beat_cnt_q != ppi_q);
  assign stray   = bus.bus_en && !beat_ok;

  // Current pack register with the incoming beat dropped into its lane.
  always_comb begin
    beat_word = pack_q;
    for (int l = 0; l < PACK; l++) begin
      if (lane_cnt_q == LaneW'(l)) begin
        beat_word[l*DATA_WIDTH +: DATA_WIDTH] = bus.bus_data;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    source_id_d      = source_id_q;
    id_last_d        = id_last_q;
    ppi_d            = ppi_q;
    beat_cnt_d       = beat_cnt_q;
    lane_cnt_d       = lane_cnt_q;
    pack_d           = pack_q;
    psum_out_start_d = 1'b0;
    err_d            = err_q;
    push             = 1'b0;
    push_word        = pack_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d     = StIssue;
          source_id_d = bus.id_first;
          id_last_d   = bus.id_last;
          ppi_d       = bus.psum_per_id;
          lane_cnt_d  = '0;
          pack_d      = '0;
          err_d       = 1'b0;
        end
      end

      StIssue: begin
        if (fifo_empty) begin
          psum_out_start_d = 1'b1;
          beat_cnt_d       = '0;
          state_d          = StCollect;
        end
      end

      StCollect: begin
        if (beat_ok) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
          if (lane_cnt_q == LaneW'(PACK - 1)) begin
            lane_cnt_d = '0;
            pack_d     = '0;
            push_word  = beat_word;
            // A full FIFO with no pop this cycle loses the word.
            if (fifo_full && !pop) begin
              err_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
            pack_d     = beat_word;
          end
        end
        if (beat_cnt_d == ppi_q) begin
          if (source_id_q == id_last_q) begin
            state_d = StFlush;
          end else begin
            source_id_d = source_id_q + 1'b1;
            state_d     = StIssue;
          end
        end
      end

      StFlush: begin
        if (lane_cnt_q == '0) begin
          state_d = StDone;
        end else if (!fifo_full || pop) begin
          push       = 1'b1;
          push_word  = pack_q;
          lane_cnt_d = '0;
          pack_d     = '0;
          state_d    = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (stray) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      source_id_q      <= '0;
      id_last_q        <= '0;
      ppi_q            <= '0;
      beat_cnt_q       <= '0;
      lane_cnt_q       <= '0;
      pack_q           <= '0;
      psum_out_start_q <= 1'b0;
      err_q            <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      state_q          <= state_d;
      source_id_q      <= source_id_d;
      id_last_q        <= id_last_d;
      ppi_q            <= ppi_d;
      beat_cnt_q       <= beat_cnt_d;
      lane_cnt_q       <= lane_cnt_d;
      pack_q           <= pack_d;
      psum_out_start_q <= psum_out_start_d;
      err_q            <= err_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_word;
    end
  end

  assign bus.source_id      = source_id_q;
  assign bus.psum_out_start = psum_out_start_q;
  assign bus.out_valid      = !fifo_empty;
  assign bus.out_data       = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = (state_q == StDone);
  assign bus.err            = err_q;

endmodule

// File: tb/tb_psum_out_collector.sv
// Randomized bench for psum_out_collector: a PE model answers each psum_out_start and the
// collected words are compared against the beat stream chunked into PACK-wide words.
module tb_psum_out_collector;

  localparam int unsigned DW = 16;
  localparam int unsigned IW = 8;
  localparam int unsigned PK = 4;
  localparam int unsigned FD = 8;

  logic clk;
  logic rst;

  psum_out_collector_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .PACK(PK)) pif ();

  psum_out_collector #(
    .DATA_WIDTH(DW),
    .ID_WIDTH  (IW),
    .PACK      (PK),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [PK*DW-1:0] got_words[$];
  logic [IW-1:0]    got_ids[$];
  int               done_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (pif.out_valid && pif.out_ready) got_words.push_back(pif.out_data);
    if (pif.psum_out_start) got_ids.push_back(pif.source_id);
    if (pif.done) done_cnt++;
  end

  task automatic chk_reset(input string pfx);
    check({pfx, "_source_id"}, 64'(pif.source_id), 64'd0);
    check({pfx, "_pos"},       64'(pif.psum_out_start), 64'd0);
    check({pfx, "_out_valid"}, 64'(pif.out_valid), 64'd0);
    check({pfx, "_out_data"},  64'(pif.out_data), 64'd0);
    check({pfx, "_busy"},      64'(pif.busy), 64'd0);
    check({pfx, "_done"},      64'(pif.done), 64'd0);
    check({pfx, "_err"},       64'(pif.err), 64'd0);
  endtask

  // One complete run. Entered and left just after a rising edge.
  task automatic run_case(input logic [IW-1:0] idf, input logic [IW-1:0] idl, input int ppi,
                          input bit counting, input int base, input int hold, input int keep,
                          input bit exp_err, input bit chk_stall);
    logic [DW-1:0]    beats[$];
    logic [PK*DW-1:0] exp_words[$];
    logic [IW-1:0]    exp_ids[$];
    logic [IW-1:0]    span;
    logic [PK*DW-1:0] w;
    int               n_ids, total, pe_idx, beats_left, cyc, n;

    span  = idl - idf;
    n_ids = int'(span) + 1;
    total = n_ids * ppi;
    for (int i = 0; i < n_ids; i++) exp_ids.push_back(idf + IW'(i));
    for (int k = 0; k < total; k++) beats.push_back(counting ? DW'(base + k) : DW'($urandom));
    // Whole-run beat stream cut into PACK-wide words, last one zero-padded.
    for (int k = 0; k < total; k += PK) begin
      w = '0;
      for (int l = 0; l < PK; l++) if (k + l < total) w[l*DW +: DW] = beats[k+l];
      exp_words.push_back(w);
    end
    while (keep >= 0 && exp_words.size() > keep) void'(exp_words.pop_back());

    got_words.delete();
    got_ids.delete();
    done_cnt         = 0;
    pif.start        = 1'b1;
    pif.id_first     = idf;
    pif.id_last      = idl;
    pif.psum_per_id  = 16'(ppi);
    pif.out_ready    = (hold == 0);
    beats_left = 0;
    pe_idx     = 0;
    cyc        = 0;

    while (done_cnt == 0 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      pif.start     = 1'b0;
      pif.out_ready = (cyc >= hold) ? ($urandom_range(0, 3) != 0) : 1'b0;
      pif.bus_en    = 1'b0;
      pif.bus_data  = '0;
      if (cyc == 1) begin
        check("busy_rise", 64'(pif.busy), 64'd1);
        check("err_clear_on_start", 64'(pif.err), 64'd0);
      end
      if (chk_stall && cyc == hold - 1) begin
        check("stall_one_id", 64'(got_ids.size()), 64'd1);
        check("stall_busy", 64'(pif.busy), 64'd1);
      end
      if (pif.psum_out_start) begin
        beats_left = ppi;
      end else if (beats_left > 0 && $urandom_range(0, 3) != 0 && pe_idx < beats.size()) begin
        pif.bus_en   = 1'b1;
        pif.bus_data = beats[pe_idx];
        pe_idx++;
        beats_left--;
        // A start while busy must be ignored.
        if ($urandom_range(0, 15) == 0) begin
          pif.start       = 1'b1;
          pif.id_first    = idf + 8'd77;
          pif.psum_per_id = 16'(ppi + 1);
        end
      end
    end

    pif.start     = 1'b0;
    pif.bus_en    = 1'b0;
    pif.out_ready = 1'b1;
    n = 0;
    while (pif.out_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("drained", 64'(pif.out_valid), 64'd0);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("busy_end", 64'(pif.busy), 64'd0);
    check("err_end", 64'(pif.err), 64'(exp_err));
    check("n_ids", 64'(got_ids.size()), 64'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < got_ids.size(); i++)
      check($sformatf("id%0d", i), 64'(got_ids[i]), 64'(exp_ids[i]));
    check("n_words", 64'(got_words.size()), 64'(exp_words.size()));
    for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
      check($sformatf("word%0d", i), got_words[i], exp_words[i]);
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    pif.start       = 1'b0;
    pif.id_first    = '0;
    pif.id_last     = '0;
    pif.psum_per_id = '0;
    pif.bus_data    = '0;
    pif.bus_en      = 1'b0;
    pif.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic two-ID run with counting data.
    run_case(8'd2, 8'd3, 4, 1'b1, 1, 0, -1, 1'b0, 1'b0);
    if (got_words.size() == 2) begin
      check("basic_w0", got_words[0], 64'h0004_0003_0002_0001);
      check("basic_w1", got_words[1], 64'h0008_0007_0006_0005);
    end

    // Partial word flushed with zero upper lane.
    run_case(8'd5, 8'd5, 3, 1'b1, 'hA, 0, -1, 1'b0, 1'b0);
    if (got_words.size() == 1) check("partial_w0", got_words[0], 64'h0000_000C_000B_000A);

    // Backpressure: ISSUE must stall until the FIFO empties.
    run_case(8'd0, 8'd2, 8, 1'b0, 0, 80, -1, 1'b0, 1'b1);

    // Zero count with ID wrap.
    run_case(8'd255, 8'd0, 0, 1'b0, 0, 0, -1, 1'b0, 1'b0);

    // Over-capacity run with no drain: the ninth word is dropped and err is set.
    run_case(8'd9, 8'd9, 36, 1'b0, 0, 100000, FD, 1'b1, 1'b0);

    // Stray beat in IDLE.
    pif.bus_en   = 1'b1;
    pif.bus_data = 16'h1234;
    @(posedge clk); #1;
    pif.bus_en = 1'b0;
    check("stray_err", 64'(pif.err), 64'd1);
    check("stray_fifo", 64'(pif.out_valid), 64'd0);
    @(posedge clk); #1;
    check("stray_busy", 64'(pif.busy), 64'd0);
    run_case(8'd7, 8'd8, 5, 1'b0, 0, 0, -1, 1'b0, 1'b0);

    // Reset in the middle of COLLECT.
    pif.start       = 1'b1;
    pif.id_first    = 8'd1;
    pif.id_last     = 8'd1;
    pif.psum_per_id = 16'd4;
    pif.out_ready   = 1'b1;
    @(posedge clk); #1;
    pif.start = 1'b0;
    n = 0;
    while (!pif.psum_out_start && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_run_pos", 64'(pif.psum_out_start), 64'd1);
    repeat (2) begin
      @(posedge clk); #1;
      pif.bus_en   = 1'b1;
      pif.bus_data = DW'($urandom);
    end
    @(posedge clk); #1;
    pif.bus_en = 1'b0;
    rst        = 1'b1;
    @(posedge clk); #1;
    chk_reset("midrst");
    rst = 1'b0;
    @(posedge clk); #1;
    run_case(8'd3, 8'd3, 4, 1'b0, 0, 0, -1, 1'b0, 1'b0);

    // Random runs within the capacity rule.
    for (int it = 0; it < 10; it++) begin
      logic [IW-1:0] f;
      f = IW'($urandom);
      run_case(f, f + IW'($urandom_range(0, 3)), int'($urandom_range(0, (FD - 1) * PK)), 1'b0, 0,
               int'($urandom_range(0, 20)), -1, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
